mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_watchdog.sv | 24 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [1:0] MODE_BYTE = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_WORD = 2'b11;
endpackage

// File: rtl/arb_watchdog.sv
// Grant-duration counter; expired flags the cycle whose increment would reach TIMEOUT.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= 8'd0;
        end else if (enable) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expired = enable && (count_reg == LAST_COUNT);
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and data ports,
// with a per-grant watchdog that aborts accesses whose memDone never arrives.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iReq,
    input  logic [31:0] iAddr,
    output logic        iAck,
    output logic [31:0] iData,
    input  logic        dReq,
    input  logic        dWrite,
    input  logic [1:0]  dMode,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    output logic        dAck,
    output logic [31:0] dData,
    output logic        memReq,
    output logic        memWrite,
    output logic [1:0]  memMode,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memDone,
    input  logic [31:0] memRData,
    output logic        timeoutErr
);
    arb_state_t  state_reg, state_next;
    grant_t      last_reg, last_next;
    logic        mem_req_reg, mem_req_next;
    logic        mem_write_reg, mem_write_next;
    logic [1:0]  mem_mode_reg, mem_mode_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        i_ack_reg, i_ack_next;
    logic        d_ack_reg, d_ack_next;
    logic        timeout_err_reg, timeout_err_next;
    logic [31:0] i_data_reg, i_data_next;
    logic [31:0] d_data_reg, d_data_next;
    logic        i_pend, d_pend, expired, in_grant;

    // A requester is still holding req during its ack cycle, so mask it there.
    assign i_pend   = iReq && !i_ack_reg;
    assign d_pend   = dReq && !d_ack_reg;
    assign in_grant = (state_reg != IDLE);

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_grant),
        .enable  (in_grant && !memDone),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            last_reg        <= GNT_I;
            mem_req_reg     <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_mode_reg    <= 2'b00;
            mem_addr_reg    <= 32'd0;
            mem_wdata_reg   <= 32'd0;
            i_ack_reg       <= 1'b0;
            d_ack_reg       <= 1'b0;
            timeout_err_reg <= 1'b0;
            i_data_reg      <= 32'd0;
            d_data_reg      <= 32'd0;
        end else begin
            state_reg       <= state_next;
            last_reg        <= last_next;
            mem_req_reg     <= mem_req_next;
            mem_write_reg   <= mem_write_next;
            mem_mode_reg    <= mem_mode_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            i_ack_reg       <= i_ack_next;
            d_ack_reg       <= d_ack_next;
            timeout_err_reg <= timeout_err_next;
            i_data_reg      <= i_data_next;
            d_data_reg      <= d_data_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        last_next        = last_reg;
        mem_req_next     = mem_req_reg;
        mem_write_next   = mem_write_reg;
        mem_mode_next    = mem_mode_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        i_ack_next       = 1'b0;
        d_ack_next       = 1'b0;
        timeout_err_next = 1'b0;
        i_data_next      = i_data_reg;
        d_data_next      = d_data_reg;

        case (state_reg)
            IDLE: begin
                if (d_pend && (!i_pend || last_reg == GNT_I)) begin
                    state_next     = GRANT_D;
                    last_next      = GNT_D;
                    mem_req_next   = 1'b1;
                    mem_write_next = dWrite;
                    mem_mode_next  = dMode;
                    mem_addr_next  = dAddr;
                    mem_wdata_next = dWData;
                end else if (i_pend) begin
                    state_next     = GRANT_I;
                    last_next      = GNT_I;
                    mem_req_next   = 1'b1;
                    mem_write_next = 1'b0;
                    mem_mode_next  = MODE_WORD;
                    mem_addr_next  = iAddr;
                    mem_wdata_next = 32'd0;
                end
            end
            GRANT_I, GRANT_D: begin
                // memDone wins over an expiry on the same edge.
                if (memDone || expired) begin
                    state_next       = IDLE;
                    mem_req_next     = 1'b0;
                    mem_write_next   = 1'b0;
                    mem_mode_next    = 2'b00;
                    mem_addr_next    = 32'd0;
                    mem_wdata_next   = 32'd0;
                    timeout_err_next = !memDone;
                    if (state_reg == GRANT_I) begin
                        i_ack_next = 1'b1;
                        if (memDone) i_data_next = memRData;
                    end else begin
                        d_ack_next = 1'b1;
                        if (memDone && !mem_write_reg) d_data_next = memRData;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign iAck       = i_ack_reg;
    assign iData      = i_data_reg;
    assign dAck       = d_ack_reg;
    assign dData      = d_data_reg;
    assign memReq     = mem_req_reg;
    assign memWrite   = mem_write_reg;
    assign memMode    = mem_mode_reg;
    assign memAddr    = mem_addr_reg;
    assign memWData   = mem_wdata_reg;
    assign timeoutErr = timeout_err_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 4-cycle watchdog.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        iReq;
    logic [31:0] iAddr;
    logic        iAck;
    logic [31:0] iData;
    logic        dReq, dWrite;
    logic [1:0]  dMode;
    logic [31:0] dAddr, dWData;
    logic        dAck;
    logic [31:0] dData;
    logic        memReq, memWrite;
    logic [1:0]  memMode;
    logic [31:0] memAddr, memWData;
    logic        memDone;
    logic [31:0] memRData;
    logic        timeoutErr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iData(iData),
        .dReq(dReq), .dWrite(dWrite), .dMode(dMode), .dAddr(dAddr),
        .dWData(dWData), .dAck(dAck), .dData(dData),
        .memReq(memReq), .memWrite(memWrite), .memMode(memMode),
        .memAddr(memAddr), .memWData(memWData),
        .memDone(memDone), .memRData(memRData), .timeoutErr(timeoutErr)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        iReq = 0; iAddr = 0; dReq = 0; dWrite = 0; dMode = 0; dAddr = 0; dWData = 0;
        memDone = 0; memRData = 0;
        do_reset();
        total++;
        if ({memReq, memWrite, memMode, iAck, dAck, timeoutErr} !== 7'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 0", {memReq, memWrite, memMode, iAck, dAck, timeoutErr});
        end
        total++;
        if ({iData, dData, memAddr, memWData} !== 128'd0) begin
            bad++;
            $display("FAIL reset_data: iData=%h dData=%h memAddr=%h memWData=%h expected 0", iData, dData, memAddr, memWData);
        end
        $display("reset: memReq=%b iData=%h dData=%h", memReq, iData, dData);
    endtask

    task automatic test_fetch();
        iReq = 1; iAddr = 32'h0040_0000;
        tick();
        total++;
        if (memReq !== 1'b1 || memAddr !== 32'h0040_0000 || memMode !== 2'b11 || memWrite !== 1'b0) begin
            bad++;
            $display("FAIL fetch_grant: memReq=%b memAddr=%h memMode=%b memWrite=%b expected 1 00400000 11 0", memReq, memAddr, memMode, memWrite);
        end
        tick();
        total++;
        if (memReq !== 1'b1 || iAck !== 1'b0) begin
            bad++;
            $display("FAIL fetch_hold: memReq=%b iAck=%b expected 1 0", memReq, iAck);
        end
        tick();
        memDone = 1; memRData = 32'h2008_0005;
        tick();
        memDone = 0; iReq = 0;
        total++;
        if (iAck !== 1'b1 || iData !== 32'h2008_0005 || memReq !== 1'b0 || timeoutErr !== 1'b0 || dAck !== 1'b0) begin
            bad++;
            $display("FAIL fetch_ack: iAck=%b iData=%h memReq=%b timeoutErr=%b dAck=%b expected 1 20080005 0 0 0", iAck, iData, memReq, timeoutErr, dAck);
        end
        tick();
        total++;
        if (iAck !== 1'b0 || iData !== 32'h2008_0005 || memReq !== 1'b0) begin
            bad++;
            $display("FAIL fetch_after: iAck=%b iData=%h memReq=%b expected 0 20080005 0", iAck, iData, memReq);
        end
        $display("fetch: addr=00400000 iData=%h", iData);
    endtask

    task automatic test_tie();
        do_reset();
        iReq = 1; iAddr = 32'h0040_0100;
        dReq = 1; dWrite = 0; dMode = 2'b11; dAddr = 32'h1001_0000; dWData = 0;
        tick();
        total++;
        if (memReq !== 1'b1 || memAddr !== 32'h1001_0000) begin
            bad++;
            $display("FAIL tie_first_d: memReq=%b memAddr=%h expected 1 10010000", memReq, memAddr);
        end
        memDone = 1; memRData = 32'h1111_2222;
        tick();
        memDone = 0; dReq = 0;
        total++;
        if (dAck !== 1'b1 || iAck !== 1'b0 || dData !== 32'h1111_2222) begin
            bad++;
            $display("FAIL tie_d_ack: dAck=%b iAck=%b dData=%h expected 1 0 11112222", dAck, iAck, dData);
        end
        tick();
        total++;
        if (memReq !== 1'b1 || memAddr !== 32'h0040_0100 || memMode !== 2'b11) begin
            bad++;
            $display("FAIL tie_then_i: memReq=%b memAddr=%h memMode=%b expected 1 00400100 11", memReq, memAddr, memMode);
        end
        memDone = 1; memRData = 32'hCAFE_0001;
        tick();
        memDone = 0; iReq = 0;
        total++;
        if (iAck !== 1'b1 || dAck !== 1'b0 || iData !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL tie_i_ack: iAck=%b dAck=%b iData=%h expected 1 0 cafe0001", iAck, dAck, iData);
        end
        tick();
        iReq = 1; dReq = 1; dAddr = 32'h1001_0040;
        tick();
        total++;
        if (memReq !== 1'b1 || memAddr !== 32'h1001_0040) begin
            bad++;
            $display("FAIL tie_second_d: memReq=%b memAddr=%h expected 1 10010040", memReq, memAddr);
        end
        memDone = 1; memRData = 32'h3333_4444;
        tick();
        memDone = 0; dReq = 0; iReq = 0;
        total++;
        if (dAck !== 1'b1 || iAck !== 1'b0 || dData !== 32'h3333_4444) begin
            bad++;
            $display("FAIL tie_d_ack2: dAck=%b iAck=%b dData=%h expected 1 0 33334444", dAck, iAck, dData);
        end
        tick();
        $display("tie: round-robin D,I,D dData=%h", dData);
    endtask

    task automatic test_store();
        dReq = 1; dWrite = 1; dMode = 2'b01; dAddr = 32'h1001_0003; dWData = 32'h0000_00AB;
        tick();
        total++;
        if (memReq !== 1'b1 || memWrite !== 1'b1 || memMode !== 2'b01 || memAddr !== 32'h1001_0003 || memWData !== 32'h0000_00AB) begin
            bad++;
            $display("FAIL store_grant: memReq=%b memWrite=%b memMode=%b memAddr=%h memWData=%h expected 1 1 01 10010003 000000ab", memReq, memWrite, memMode, memAddr, memWData);
        end
        memDone = 1; memRData = 32'hDEAD_BEEF;
        tick();
        memDone = 0; dReq = 0; dWrite = 0;
        total++;
        if (dAck !== 1'b1 || dData !== 32'h3333_4444 || timeoutErr !== 1'b0) begin
            bad++;
            $display("FAIL store_ack: dAck=%b dData=%h timeoutErr=%b expected 1 33334444 0", dAck, dData, timeoutErr);
        end
        tick();
        $display("store: addr=10010003 dData=%h", dData);
    endtask

    task automatic test_timeout();
        dReq = 1; dWrite = 0; dMode = 2'b11; dAddr = 32'h1001_0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (memReq !== 1'b1 || dAck !== 1'b0) begin
                bad++;
                $display("FAIL timeout_wait%0d: memReq=%b dAck=%b expected 1 0", i, memReq, dAck);
            end
        end
        tick();
        dReq = 0;
        total++;
        if (memReq !== 1'b0 || dAck !== 1'b1 || timeoutErr !== 1'b1 || dData !== 32'h3333_4444) begin
            bad++;
            $display("FAIL timeout_ack: memReq=%b dAck=%b timeoutErr=%b dData=%h expected 0 1 1 33334444", memReq, dAck, timeoutErr, dData);
        end
        tick();
        total++;
        if (memReq !== 1'b0 || dAck !== 1'b0 || timeoutErr !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: memReq=%b dAck=%b timeoutErr=%b expected 0 0 0", memReq, dAck, timeoutErr);
        end
        $display("timeout: dAck with timeoutErr after 4 memReq cycles");
    endtask

    task automatic test_reset_mid_grant();
        iReq = 1; iAddr = 32'h0040_0008;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0; iReq = 0; memDone = 1; memRData = 32'hBAD0_BAD0;
        total++;
        if (memReq !== 1'b0 || iAck !== 1'b0 || iData !== 32'd0) begin
            bad++;
            $display("FAIL midrst_abort: memReq=%b iAck=%b iData=%h expected 0 0 0", memReq, iAck, iData);
        end
        tick();
        memDone = 0;
        total++;
        if (memReq !== 1'b0 || iAck !== 1'b0 || iData !== 32'd0) begin
            bad++;
            $display("FAIL midrst_stale: memReq=%b iAck=%b iData=%h expected 0 0 0", memReq, iAck, iData);
        end
        iReq = 1; iAddr = 32'h0040_0010;
        tick();
        total++;
        if (memReq !== 1'b1 || memAddr !== 32'h0040_0010) begin
            bad++;
            $display("FAIL midrst_regrant: memReq=%b memAddr=%h expected 1 00400010", memReq, memAddr);
        end
        memDone = 1; memRData = 32'h5555_AAAA;
        tick();
        memDone = 0; iReq = 0;
        total++;
        if (iAck !== 1'b1 || iData !== 32'h5555_AAAA) begin
            bad++;
            $display("FAIL midrst_ack: iAck=%b iData=%h expected 1 5555aaaa", iAck, iData);
        end
        tick();
        $display("reset_mid_grant: next fetch iData=%h", iData);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_tie();
        test_store();
        test_timeout();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
